// File: rtl/rtc_bcd_counter_if.sv
// Bundles the control and display signals of the BCD real-time clock.
// The master side drives enable and time-load requests.
// The slave side (the counter) returns the time digits and the status pulses.
interface rtc_bcd_counter_if;
    logic        en;
    logic        set_valid;
    logic [23:0] set_time;
    logic        set_err;
    logic [3:0]  hh_t;
    logic [3:0]  hh_u;
    logic [3:0]  mm_t;
    logic [3:0]  mm_u;
    logic [3:0]  ss_t;
    logic [3:0]  ss_u;
    logic        sec_pulse;
    logic        day_wrap;

    modport master (
        output en, set_valid, set_time,
        input  set_err, hh_t, hh_u, mm_t, mm_u, ss_t, ss_u, sec_pulse, day_wrap
    );

    modport slave (
        input  en, set_valid, set_time,
        output set_err, hh_t, hh_u, mm_t, mm_u, ss_t, ss_u, sec_pulse, day_wrap
    );
endinterface

// File: rtl/rtc_bcd_counter.sv
// 24-hour BCD time-of-day counter.
// A prescaler divides clk down to one tick per second.
// Each tick advances the six BCD digits with the usual carries.
// A load request replaces the time when every digit is in range; otherwise it is
// rejected and set_err pulses.
module rtc_bcd_counter #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic               clk,
    input  logic               rst_n,
    rtc_bcd_counter_if.slave   bus
);

    localparam int unsigned     PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PS_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [3:0]    hh_t_q, hh_u_q, mm_t_q, mm_u_q, ss_t_q, ss_u_q;
    logic          sec_pulse_q, day_wrap_q, set_err_q;

    logic [3:0]    hh_t_n, hh_u_n, mm_t_n, mm_u_n, ss_t_n, ss_u_n;
    logic [3:0]    ld_hh_t, ld_hh_u, ld_mm_t, ld_mm_u, ld_ss_t, ld_ss_u;
    logic          tick;
    logic          load_ok;
    logic          at_day_end;

    assign {ld_hh_t, ld_hh_u, ld_mm_t, ld_mm_u, ld_ss_t, ld_ss_u} = bus.set_time;

    // A pending load blocks the tick; a discarded tick is not deferred to the next cycle.
    assign tick = bus.en && (presc_q == PS_MAX) && !bus.set_valid;

    assign at_day_end = (hh_t_q == 4'd2) && (hh_u_q == 4'd3) &&
                        (mm_t_q == 4'd5) && (mm_u_q == 4'd9) &&
                        (ss_t_q == 4'd5) && (ss_u_q == 4'd9);

    // Accept only time values the display can legally show (00:00:00 .. 23:59:59).
    always_comb begin
        load_ok = (ld_ss_u <= 4'd9) && (ld_ss_t <= 4'd5) &&
                  (ld_mm_u <= 4'd9) && (ld_mm_t <= 4'd5) &&
                  ((ld_hh_t <  4'd2 && ld_hh_u <= 4'd9) ||
                   (ld_hh_t == 4'd2 && ld_hh_u <= 4'd3));
    end

    // Time plus one second, rippling the carry from seconds units up to hours.
    always_comb begin
        hh_t_n = hh_t_q;
        hh_u_n = hh_u_q;
        mm_t_n = mm_t_q;
        mm_u_n = mm_u_q;
        ss_t_n = ss_t_q;
        ss_u_n = ss_u_q;
        if (ss_u_q != 4'd9) begin
            ss_u_n = ss_u_q + 4'd1;
        end else begin
            ss_u_n = 4'd0;
            if (ss_t_q != 4'd5) begin
                ss_t_n = ss_t_q + 4'd1;
            end else begin
                ss_t_n = 4'd0;
                if (mm_u_q != 4'd9) begin
                    mm_u_n = mm_u_q + 4'd1;
                end else begin
                    mm_u_n = 4'd0;
                    if (mm_t_q != 4'd5) begin
                        mm_t_n = mm_t_q + 4'd1;
                    end else begin
                        mm_t_n = 4'd0;
                        if (hh_t_q == 4'd2 && hh_u_q == 4'd3) begin
                            hh_t_n = 4'd0;
                            hh_u_n = 4'd0;
                        end else if (hh_u_q == 4'd9) begin
                            hh_u_n = 4'd0;
                            hh_t_n = hh_t_q + 4'd1;
                        end else begin
                            hh_u_n = hh_u_q + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Prescaler: clears on a load or a tick, counts while enabled, and holds on a rejected load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (bus.set_valid) begin
            if (load_ok) begin
                presc_q <= '0;
            end
        end else if (tick) begin
            presc_q <= '0;
        end else if (bus.en) begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Time digits: a load has priority over the one-second advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {hh_t_q, hh_u_q, mm_t_q, mm_u_q, ss_t_q, ss_u_q} <= '0;
        end else if (bus.set_valid && load_ok) begin
            {hh_t_q, hh_u_q, mm_t_q, mm_u_q, ss_t_q, ss_u_q} <= bus.set_time;
        end else if (tick) begin
            {hh_t_q, hh_u_q, mm_t_q, mm_u_q, ss_t_q, ss_u_q} <=
                {hh_t_n, hh_u_n, mm_t_n, mm_u_n, ss_t_n, ss_u_n};
        end
    end

    // Status pulses: registered one cycle after the event that caused them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sec_pulse_q <= 1'b0;
            day_wrap_q  <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            sec_pulse_q <= tick;
            day_wrap_q  <= tick && at_day_end;
            set_err_q   <= bus.set_valid && !load_ok;
        end
    end

    assign bus.hh_t      = hh_t_q;
    assign bus.hh_u      = hh_u_q;
    assign bus.mm_t      = mm_t_q;
    assign bus.mm_u      = mm_u_q;
    assign bus.ss_t      = ss_t_q;
    assign bus.ss_u      = ss_u_q;
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.day_wrap  = day_wrap_q;
    assign bus.set_err   = set_err_q;

endmodule

// File: tb/tb_rtc_bcd_counter.sv
// Directed bench for rtc_bcd_counter with TICK_DIV=4.
module tb_rtc_bcd_counter;

    logic clk;
    logic rst_n;
    rtc_bcd_counter_if bus ();

    rtc_bcd_counter #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        sv;
        logic [23:0] st;
        logic [23:0] t;
        logic        sec;
        logic        wrap;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [23:0] cur_time();
        return {bus.hh_t, bus.hh_u, bus.mm_t, bus.mm_u, bus.ss_t, bus.ss_u};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic s, input logic [23:0] st,
                       input logic [23:0] t, input logic sec, input logic wrap, input logic err);
        vec_t v;
        v.rst_n = r; v.en = e; v.sv = s; v.st = st;
        v.t = t; v.sec = sec; v.wrap = wrap; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic s, input logic [23:0] st);
        rst_n         = r;
        bus.en        = e;
        bus.set_valid = s;
        bus.set_time  = st;
    endtask

    task automatic check_all(input string tag, input logic [23:0] t, input logic sec,
                             input logic wrap, input logic err);
        check({tag, ".time"}, cur_time(), t);
        check({tag, ".sec"}, 24'(bus.sec_pulse), 24'(sec));
        check({tag, ".wrap"}, 24'(bus.day_wrap), 24'(wrap));
        check({tag, ".err"}, 24'(bus.set_err), 24'(err));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 24'h0);

        // rst, en, set_valid, set_time, exp time, sec, wrap, err
        add(0, 0, 0, 24'h000000, 24'h000000, 0, 0, 0);
        add(1, 0, 1, 24'h246000, 24'h000000, 0, 0, 1);
        add(1, 0, 1, 24'h120960, 24'h000000, 0, 0, 1);
        add(1, 0, 1, 24'h240000, 24'h000000, 0, 0, 1);
        add(1, 0, 0, 24'h000000, 24'h000000, 0, 0, 0);
        add(1, 0, 1, 24'h123456, 24'h123456, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h123456, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h123456, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h123456, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h123457, 1, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h123457, 0, 0, 0);
        add(1, 0, 0, 24'h000000, 24'h123457, 0, 0, 0);
        add(1, 1, 1, 24'h1A0000, 24'h123457, 0, 0, 1);
        add(1, 1, 0, 24'h000000, 24'h123457, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h123457, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h123458, 1, 0, 0);
        add(1, 0, 1, 24'h195959, 24'h195959, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h195959, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h195959, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h195959, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h200000, 1, 0, 0);
        add(1, 0, 1, 24'h235959, 24'h235959, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h235959, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h235959, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h235959, 0, 0, 0);
        add(1, 1, 0, 24'h000000, 24'h000000, 1, 1, 0);
        add(1, 1, 0, 24'h000000, 24'h000000, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].sv, vecs[i].st);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].t, vecs[i].sec, vecs[i].wrap, vecs[i].err);
        end

        // Basic counting from reset: pulse every 4th cycle, 10 s after 40 cycles.
        drive(1'b0, 1'b1, 1'b0, 24'h0);
        step();
        check_all("cnt.reset", 24'h000000, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 24'h0);
        for (int c = 1; c <= 40; c++) begin
            step();
            check($sformatf("cnt.sec%0d", c), 24'(bus.sec_pulse), 24'((c % 4) == 0));
        end
        check("cnt.time", cur_time(), 24'h000010);

        // Day wrap from 23:59:58.
        drive(1'b1, 1'b0, 1'b1, 24'h235958);
        step();
        check("wrap.load", cur_time(), 24'h235958);
        drive(1'b1, 1'b1, 1'b0, 24'h0);
        for (int c = 1; c <= 8; c++) begin
            step();
            check_all($sformatf("wrap.c%0d", c),
                      (c < 4) ? 24'h235958 : (c < 8) ? 24'h235959 : 24'h000000,
                      (c % 4) == 0, c == 8, 1'b0);
        end
        step();
        check_all("wrap.after", 24'h000000, 0, 0, 0);

        // Load colliding with a tick: prescaler brought to 3 first.
        drive(1'b1, 1'b0, 1'b1, 24'h000000);
        step();
        drive(1'b1, 1'b1, 1'b0, 24'h0);
        step(); step(); step();
        check("coll.pre", cur_time(), 24'h000000);
        drive(1'b1, 1'b1, 1'b1, 24'h095959);
        step();
        check_all("coll.load", 24'h095959, 0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 24'h0);
        for (int c = 1; c <= 4; c++) begin
            step();
            check_all($sformatf("coll.c%0d", c), (c < 4) ? 24'h095959 : 24'h100000,
                      c == 4, 1'b0, 1'b0);
        end

        // Pause mid-second with the prescaler at 2.
        step(); step();
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        for (int c = 1; c <= 20; c++) begin
            step();
            check_all($sformatf("pause.c%0d", c), 24'h100000, 0, 0, 0);
        end
        drive(1'b1, 1'b1, 1'b0, 24'h0);
        step();
        check_all("pause.r1", 24'h100000, 0, 0, 0);
        step();
        check_all("pause.r2", 24'h100001, 1, 0, 0);

        // Reset during a valid and then an invalid load.
        drive(1'b1, 1'b0, 1'b1, 24'h123456);
        step();
        check("rst.pre", cur_time(), 24'h123456);
        drive(1'b0, 1'b1, 1'b1, 24'h111111);
        step();
        check_all("rst.valid", 24'h000000, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b1, 24'h123456);
        step();
        drive(1'b0, 1'b1, 1'b1, 24'h990000);
        step();
        check_all("rst.invalid", 24'h000000, 0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 24'h0);
        step();
        check_all("rst.release", 24'h000000, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rtc_bcd_counter.md
RTC_BCD_COUNTER -- requirements
Module: rtc_bcd_counter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000, giving the number of clk cycles per second (legal range 2 to 2^26).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port en, input, 1 bit: 1 = timekeeping runs, 0 = time and prescaler are frozen.
REQ-005 The block SHALL have port set_valid, input, 1 bit: a one-cycle request to load set_time.
REQ-006 The block SHALL have port set_time, input, 24 bits: packed BCD {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u}, 4 bits each, MSB first.
REQ-007 The block SHALL have port set_err, output, 1 bit: a one-cycle pulse flagging that a load request was rejected.
REQ-008 The block SHALL have ports hh_t, hh_u, mm_t, mm_u, ss_t, ss_u, outputs, 4 bits each: BCD time digits that drive the seven-segment decoders directly.
REQ-009 The block SHALL have port sec_pulse, output, 1 bit: a one-cycle pulse issued on each seconds advance.
REQ-010 The block SHALL have port day_wrap, output, 1 bit: a one-cycle pulse on the 23:59:59 -> 00:00:00 transition.

Function
REQ-011 The prescaler SHALL be a counter of width clog2(TICK_DIV) that counts 0..TICK_DIV-1 while en=1 and holds its value while en=0.
REQ-012 The tick SHALL be asserted in the cycle where en=1, the prescaler equals TICK_DIV-1, and set_valid=0; on a tick, the prescaler SHALL return to 0.
REQ-013 On a tick, the digits SHALL advance by one second in the same clock edge, and sec_pulse SHALL be 1 in the following cycle (registered, 1-cycle latency from the tick condition).
REQ-014 Seconds arithmetic SHALL follow these rules:
- ss_u counts 0..9.
- On ss_u=9, ss_u goes to 0 and ss_t increments.
- ss_t counts 0..5.
- On ss_t=5 with ss_u=9, both seconds digits go to 0 and the minutes carry fires.
REQ-015 Minutes SHALL use the same carry rules as seconds (mm_u 0..9, mm_t 0..5), generating the hours carry at 59.
REQ-016 Hours SHALL use 24-hour format:
- hh_u counts 0..9 while hh_t<2, and 0..3 while hh_t=2.
- Carry from 23 goes to hh_t=0, hh_u=0.
REQ-017 On a tick at 23:59:59, all digits SHALL become 0, and day_wrap and sec_pulse SHALL both pulse in the next cycle.
REQ-018 A load request SHALL be valid only when every digit is BCD in range: ss_u<=9, ss_t<=5, mm_u<=9, mm_t<=5, and hours 00..23.
REQ-019 A valid set_valid SHALL, on that edge:
- Load all six digits.
- Clear the prescaler to 0.
- Produce no sec_pulse or day_wrap for that edge.
REQ-020 An invalid set_valid SHALL leave digits and prescaler unchanged and SHALL make set_err 1 in the next cycle for one cycle.
REQ-021 Load SHALL take priority over a simultaneous tick; the tick is discarded, not deferred.
REQ-022 Load SHALL be accepted regardless of en.
REQ-023 When en=0 and no load occurs, the block SHALL drive sec_pulse=0 and day_wrap=0.
REQ-024 Digit outputs SHALL be registered and SHALL never hold a non-BCD or out-of-range value.

Reset
REQ-025 When rst_n=0 at a rising clk edge, the block SHALL set:
- All six digits to 0.
- The prescaler to 0.
- sec_pulse, day_wrap and set_err to 0.
REQ-026 Reset SHALL override set_valid and tick in the same cycle, including a reset asserted mid-count or mid-load.
REQ-027 After rst_n returns to 1 with en=1, the first sec_pulse SHALL occur TICK_DIV cycles after the first non-reset edge.

Verification (TICK_DIV=4)
REQ-028 Scenario, basic counting:
- Stimulus: reset, then en=1 for 40 cycles.
- Required response: sec_pulse every 4th cycle; after 10 ticks, ss_t=1 and ss_u=0.
REQ-029 Scenario, day wrap:
- Stimulus: load 0x235958, en=1, run 8 cycles.
- Required response: digits pass through 23:59:59, then read 00:00:00 with day_wrap=1 for exactly one cycle, coincident with sec_pulse.
REQ-030 Scenario, invalid loads:
- Stimulus: load 0x246000, then load 0x120960.
- Required response: set_err pulses once for each request; digits are unchanged both times.
REQ-031 Scenario, load/tick collision:
- Stimulus: assert set_valid with 0x095959 exactly when the prescaler is 3.
- Required response: the digits are exactly 09:59:59 with no sec_pulse; the next tick gives 10:00:00.
REQ-032 Scenario, pause:
- Stimulus: en=0 for 20 cycles mid-second.
- Required response: digits and prescaler are frozen and there are no pulses; the count resumes from the held prescaler value.
REQ-033 Scenario, reset mid-operation:
- Stimulus: assert rst_n=0 for one cycle at 12:34:56, concurrent with set_valid.
- Required response: all digits are 0, set_err=0, and the load is ignored.
